nic: RTL and testbench
======================

NIC -- requirements
Module: nic

Interface
REQ-001 The parameter DATA_WIDTH SHALL default to 64 and set the width of every packet and data port; bit DATA_WIDTH-1 is the packet VC bit.
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide, asynchronous and active-low.
REQ-004 The port addr SHALL be an input, 2 bits wide, and selects the processor-side register.
REQ-005 The port d_in SHALL be an input, DATA_WIDTH bits wide, and carries processor write data.
REQ-006 The port d_out SHALL be an output, DATA_WIDTH bits wide, and carries processor read data.
REQ-007 The port nicEn SHALL be an input, 1 bit wide, and is the processor access enable.
REQ-008 The port nicWrEn SHALL be an input, 1 bit wide; 1 selects a write and 0 selects a read, qualified by nicEn.
REQ-009 The port net_si SHALL be an input, 1 bit wide, and is the router-to-NIC send (router pe output send).
REQ-010 The port net_ri SHALL be an output, 1 bit wide, and is the NIC-to-router ready for incoming packets.
REQ-011 The port net_di SHALL be an input, DATA_WIDTH bits wide, and carries the router-to-NIC packet.
REQ-012 The port net_so SHALL be an output, 1 bit wide, and is the NIC-to-router send (router pesi).
REQ-013 The port net_ro SHALL be an input, 1 bit wide, and is the router ready for injection (router pero).
REQ-014 The port net_do SHALL be an output, DATA_WIDTH bits wide, and carries the NIC-to-router packet (router pedi).
REQ-015 The port net_polarity SHALL be an input, 1 bit wide, and is the router polarity.

Function
REQ-016 The register map SHALL be: addr 00 = input buffer; 01 = input status {zeros, in_full}; 10 = output buffer; 11 = output status {zeros, out_full}.
REQ-017 The block SHALL hold one input buffer (in_buf, in_full) and one output buffer (out_buf, out_full), each one packet deep.
REQ-018 A processor write (nicEn=1, nicWrEn=1, addr=10) with out_full=0 SHALL load d_in into out_buf and set out_full at the same edge.
REQ-019 A processor write to addr 10 while out_full=1 SHALL be dropped; out_buf SHALL remain unchanged.
REQ-020 Processor writes to addr 00, 01 and 11 SHALL have no effect.
REQ-021 net_do SHALL equal out_buf at all times.
REQ-022 net_so SHALL be combinational: out_full AND net_ro AND (net_polarity == out_buf[DATA_WIDTH-1]).
REQ-023 At an edge with net_so=1, out_full SHALL clear; a processor write in that same cycle SHALL be dropped per REQ-019, because out_full was 1.
REQ-024 net_ri SHALL equal NOT in_full while reset is deasserted.
REQ-025 At an edge with net_si=1 and net_ri=1, net_di SHALL be captured into in_buf and in_full SHALL be set.
REQ-026 net_si=1 while net_ri=0 SHALL be ignored; the router is responsible for not asserting it.
REQ-027 A read (nicEn=1, nicWrEn=0) SHALL drive d_out combinationally: addr 00 gives in_buf, 01 gives {0, in_full}, 10 gives out_buf, 11 gives {0, out_full}.
REQ-028 d_out SHALL be all zeros when nicEn=0 or nicWrEn=1.
REQ-029 A read of addr 00 with in_full=1 SHALL clear in_full at that edge; a read with in_full=0 SHALL return in_buf (stale data) with no state change.
REQ-030 No packet arrival SHALL coincide with an addr 00 read that clears in_full, because net_ri=0 in that cycle; a new packet is therefore accepted at the earliest one cycle after the read.
REQ-031 Input and output paths SHALL operate independently and concurrently, with no ordering between them.
REQ-032 Latency: a processor write at edge N SHALL allow net_so=1 from cycle N+1 at the earliest; a packet accepted at edge N SHALL be readable from cycle N+1.

Reset
REQ-033 While reset=0, in_full, out_full, in_buf and out_buf SHALL be forced to 0, net_so and net_ri SHALL be 0, and net_do SHALL be 0, immediately, independent of clk.
REQ-034 When reset asserts mid-transfer, any buffered packet SHALL be discarded and SHALL NOT be sent after reset releases.
REQ-035 After reset=1, net_ri SHALL go to 1 and the first edge SHALL accept traffic normally.

Verification
REQ-036 Injection: reset, then write 0x8000_0000_0000_00AB to addr 10 with net_ro=1 and net_polarity=1 -> net_so=1 one cycle later with net_do=0x8000_0000_0000_00AB, then out status reads 0.
REQ-037 Polarity hold: buffer a packet with bit63=0 while net_polarity=1 -> net_so stays 0; when net_polarity toggles to 0 -> net_so=1 and the packet is sent.
REQ-038 Full drop: with net_ro=0, write 0x11 then 0x22 to addr 10 -> out_buf=0x11, out status=1; raise net_ro -> 0x11 is sent.
REQ-039 Ejection: net_si=1 with net_di=0x1234 -> net_ri=0 next cycle and addr 01 reads 1; read addr 00 -> d_out=0x1234, then net_ri=1 next cycle.
REQ-040 Back-to-back: hold net_si=1 with two packets -> the second is accepted only after the addr 00 read, and neither packet is lost.
REQ-041 Async reset: assert reset mid-cycle with both buffers full -> net_so=0, net_ri=0 and both status registers read 0 immediately, with no send after release.

Source files
------------

// File: rtl/nic.sv
// nic: processor-to-router network interface with one-packet input and output buffers.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset        : asynchronous active-low reset
//   addr         : processor register select (00 in_buf, 01 in status, 10 out_buf, 11 out status)
//   d_in         : processor write data
//   d_out        : processor read data (combinational, zero unless a read is enabled)
//   nicEn        : processor access enable
//   nicWrEn      : 1 = write, 0 = read (qualified by nicEn)
//   net_si       : router-to-NIC send
//   net_ri       : NIC-to-router ready (input buffer empty)
//   net_di       : router-to-NIC packet
//   net_so       : NIC-to-router send (combinational)
//   net_ro       : router ready for injection
//   net_do       : NIC-to-router packet (mirrors out_buf)
//   net_polarity : router polarity; a packet leaves only when its VC bit matches it
module nic #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    localparam int unsigned VC_BIT = DATA_WIDTH - 1;

    localparam logic [1:0] ADDR_IN_BUF  = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    logic [DATA_WIDTH-1:0] in_buf_q, in_buf_d;
    logic [DATA_WIDTH-1:0] out_buf_q, out_buf_d;
    logic                  in_full_q, in_full_d;
    logic                  out_full_q, out_full_d;

    logic wr_out;
    logic rd_in;
    logic send;
    logic accept;

    // Handshake qualifiers. A write to a full output buffer is dropped, so
    // wr_out and send are mutually exclusive; likewise accept and a clearing read.
    assign wr_out = nicEn & nicWrEn & (addr == ADDR_OUT_BUF) & ~out_full_q;
    assign rd_in  = nicEn & ~nicWrEn & (addr == ADDR_IN_BUF);
    assign send   = out_full_q & net_ro & (net_polarity == out_buf_q[VC_BIT]);
    assign accept = net_si & net_ri;

    // Network-side outputs; ready is held low while reset is asserted.
    assign net_so = send;
    assign net_ri = reset & ~in_full_q;
    assign net_do = out_buf_q;

    // Next-state for both buffers.
    always_comb begin
        in_buf_d   = in_buf_q;
        in_full_d  = in_full_q;
        out_buf_d  = out_buf_q;
        out_full_d = out_full_q;

        if (accept) begin
            in_buf_d  = net_di;
            in_full_d = 1'b1;
        end else if (rd_in) begin
            in_full_d = 1'b0;
        end

        if (send) begin
            out_full_d = 1'b0;
        end else if (wr_out) begin
            out_buf_d  = d_in;
            out_full_d = 1'b1;
        end
    end

    // Processor read mux.
    always_comb begin
        d_out = '0;
        if (nicEn && !nicWrEn) begin
            case (addr)
                ADDR_IN_BUF:   d_out = in_buf_q;
                ADDR_IN_STAT:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full_q};
                ADDR_OUT_BUF:  d_out = out_buf_q;
                ADDR_OUT_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, out_full_q};
                default:       d_out = '0;
            endcase
        end
    end

    // Buffer state; reset discards any packet in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_buf_q   <= '0;
            in_full_q  <= 1'b0;
            out_buf_q  <= '0;
            out_full_q <= 1'b0;
        end else begin
            in_buf_q   <= in_buf_d;
            in_full_q  <= in_full_d;
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
        end
    end

endmodule

// File: tb/tb_nic.sv
// tb_nic: scoreboard bench for nic. Stimulus pushes expected sends and read
// data into queues; a negedge monitor pops and compares whenever the DUT
// presents a send or a processor read.
module tb_nic;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    int n_cmp = 0;
    int n_err = 0;
    bit done  = 0;

    logic [63:0] exp_send[$];
    logic [63:0] exp_read[$];

    nic #(.DATA_WIDTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    // Monitor: every negedge out of reset, sends and reads are scored.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && !done) begin
                if (net_so) begin
                    if (exp_send.size() == 0) begin
                        check("unexpected_send", net_do, 64'hDEAD_DEAD_DEAD_DEAD);
                    end else begin
                        check("send_data", net_do, exp_send.pop_front());
                    end
                end
                if (nicEn && !nicWrEn) begin
                    if (exp_read.size() == 0) begin
                        check("unexpected_read", d_out, 64'hDEAD_DEAD_DEAD_DEAD);
                    end else begin
                        check("read_data", d_out, exp_read.pop_front());
                    end
                end else begin
                    check("d_out_idle_zero", d_out, 64'd0);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        summary();
        $finish;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
        step();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [63:0] exp);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        exp_read.push_back(exp);
        step();
        nicEn = 1'b0;
    endtask

    // Check a single-bit DUT output at the negedge of the current cycle, then advance.
    task automatic chk_cyc(input string name, input logic [63:0] exp, input int sel);
        @(negedge clk);
        case (sel)
            0:       check(name, 64'(net_so), exp);
            default: check(name, 64'(net_ri), exp);
        endcase
        step();
    endtask

    initial begin
        reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;

        // Reset state
        #5;
        check("rst_net_ri", 64'(net_ri), 64'd0);
        check("rst_net_so", 64'(net_so), 64'd0);
        check("rst_net_do", net_do, 64'd0);
        step();
        reset = 1'b1;
        #1;
        check("post_rst_net_ri", 64'(net_ri), 64'd1);

        // Writes to non-output registers have no effect
        net_ro = 1'b1; net_polarity = 1'b1;
        wr(2'b00, 64'hFF);
        wr(2'b01, 64'hFF);
        wr(2'b11, 64'hFF);
        rd(2'b00, 64'd0);
        rd(2'b01, 64'd0);
        rd(2'b10, 64'd0);
        rd(2'b11, 64'd0);

        // Injection with matching polarity: send one cycle after the write
        wr(2'b10, 64'h8000_0000_0000_00AB);
        exp_send.push_back(64'h8000_0000_0000_00AB);
        chk_cyc("inject_so", 64'd1, 0);
        rd(2'b11, 64'd0);

        // Polarity hold
        wr(2'b10, 64'h0000_0000_0000_0055);
        exp_send.push_back(64'h0000_0000_0000_0055);
        for (int i = 0; i < 3; i++) chk_cyc("pol_hold_so", 64'd0, 0);
        net_polarity = 1'b0;
        chk_cyc("pol_release_so", 64'd1, 0);
        rd(2'b11, 64'd0);

        // Full drop
        net_ro = 1'b0;
        wr(2'b10, 64'h11);
        exp_send.push_back(64'h11);
        wr(2'b10, 64'h22);
        rd(2'b10, 64'h11);
        rd(2'b11, 64'd1);
        net_ro = 1'b1;
        chk_cyc("drop_send_so", 64'd1, 0);
        rd(2'b11, 64'd0);

        // Ejection
        net_si = 1'b1; net_di = 64'h1234;
        step();
        net_si = 1'b0; net_di = '0;
        chk_cyc("eject_ri_low", 64'd0, 1);
        rd(2'b01, 64'd1);
        rd(2'b00, 64'h1234);
        chk_cyc("eject_ri_high", 64'd1, 1);
        rd(2'b01, 64'd0);
        rd(2'b00, 64'h1234);
        rd(2'b01, 64'd0);

        // Back-to-back arrivals with net_si held
        net_si = 1'b1; net_di = 64'hA1;
        step();
        net_di = 64'hB2;
        idle(2);
        rd(2'b01, 64'd1);
        rd(2'b00, 64'hA1);
        step();
        net_si = 1'b0; net_di = '0;
        rd(2'b01, 64'd1);
        rd(2'b00, 64'hB2);
        rd(2'b01, 64'd0);

        // Async reset with both buffers full
        net_ro = 1'b0; net_polarity = 1'b1;
        wr(2'b10, 64'h8000_0000_0000_00CC);
        net_si = 1'b1; net_di = 64'h77;
        step();
        net_si = 1'b0; net_di = '0;
        net_ro = 1'b1;
        #1;
        check("pre_rst_so", 64'(net_so), 64'd1);
        check("pre_rst_ri", 64'(net_ri), 64'd0);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_so", 64'(net_so), 64'd0);
        check("async_rst_ri", 64'(net_ri), 64'd0);
        check("async_rst_do", net_do, 64'd0);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b01;
        #1;
        check("async_rst_in_stat", d_out, 64'd0);
        addr = 2'b11;
        #1;
        check("async_rst_out_stat", d_out, 64'd0);
        nicEn = 1'b0;
        idle(2);
        reset = 1'b1;
        #1;
        check("release_ri", 64'(net_ri), 64'd1);
        for (int i = 0; i < 3; i++) chk_cyc("no_send_after_rst", 64'd0, 0);
        rd(2'b01, 64'd0);
        rd(2'b11, 64'd0);

        // Traffic resumes normally after reset
        wr(2'b10, 64'h8000_0000_0000_0001);
        exp_send.push_back(64'h8000_0000_0000_0001);
        net_si = 1'b1; net_di = 64'h99;
        step();
        net_si = 1'b0;
        rd(2'b00, 64'h99);
        idle(2);

        done = 1'b1;
        check("send_queue_drained", 64'(exp_send.size()), 64'd0);
        check("read_queue_drained", 64'(exp_read.size()), 64'd0);
        summary();
        $finish;
    end

endmodule
